m_branch_predictor: RTL and testbench

Parametrised branch target buffer with 2-bit saturating direction counters, the successor of the single-word branch-destination memo in the IF stage. IF presents the fetch PC each cycle and receives a registered taken/target prediction the next cycle. MEM reports resolved branches through an update port, which trains the counters and allocates or replaces entries. Entry count and tag width are configurable; tags remove the aliasing of the untagged memo.

---
 rtl/m_branch_predictor_if.sv | 31 +++
 rtl/m_branch_predictor.sv | 155 +++++++++++++++
 tb/tb_m_branch_predictor.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/m_branch_predictor_if.sv
// Branch predictor port bundle: IF lookup, MEM update and statistics.
// The master side (pipeline) drives ce, lookup and update; the slave side
// (predictor) returns the registered prediction and the stat counters.
interface m_branch_predictor_if;
  logic        ce;
  logic [31:0] lookup_pc;
  logic        hit;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_mispredict;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  modport master (
    output ce, lookup_pc,
    output update_valid, update_pc, update_taken, update_target, update_mispredict,
    input  hit, predict_taken, predict_target,
    input  stat_branches, stat_mispredicts
  );

  modport slave (
    input  ce, lookup_pc,
    input  update_valid, update_pc, update_taken, update_target, update_mispredict,
    output hit, predict_taken, predict_target,
    output stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/m_branch_predictor.sv
// Tagged branch target buffer with 2-bit saturating direction counters.
// IF looks up a fetch PC and gets a registered prediction one cycle later;
// MEM trains counters and allocates/replaces entries on taken branches.
// A same-index update is forwarded into the lookup (write-first), so a
// freshly trained branch predicts on the very next fetch.
// Optional feature: define BP_STATS_EN to compile the resolved-branch and
// mispredict counters; otherwise both stat outputs are tied to zero.
module m_branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8
) (
  input logic            clk,
  input logic            rst,
  m_branch_predictor_if.slave bp
);

  localparam int IDX_W = $clog2(ENTRIES);

  // Valid bits must reset; tag/counter/target storage can live in RAM.
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [1:0]         ctr_mem    [ENTRIES];
  logic [31:0]        target_mem [ENTRIES];

  logic [IDX_W-1:0] u_idx, l_idx;
  logic [TAG_W-1:0] u_tag, l_tag;

  assign u_idx = bp.update_pc[IDX_W+1:2];
  assign u_tag = bp.update_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign l_idx = bp.lookup_pc[IDX_W+1:2];
  assign l_tag = bp.lookup_pc[IDX_W+TAG_W+1:IDX_W+2];

  logic        u_match;
  logic        wr_en;
  logic [1:0]  wr_ctr;
  logic [31:0] wr_target;

  logic        hit_q, hit_d;
  logic        predict_taken_q, predict_taken_d;
  logic [31:0] predict_target_q, predict_target_d;

  // Update path: decide whether MEM's resolved branch writes an entry and
  // compute the post-update contents. Not-taken misses never allocate.
  always_comb begin
    u_match   = valid_q[u_idx] && (tag_mem[u_idx] == u_tag);
    wr_en     = bp.ce && bp.update_valid && (u_match || bp.update_taken);
    wr_ctr    = 2'd2;
    wr_target = bp.update_taken ? bp.update_target : target_mem[u_idx];
    if (u_match) begin
      if (bp.update_taken) begin
        wr_ctr = (ctr_mem[u_idx] == 2'd3) ? 2'd3 : ctr_mem[u_idx] + 2'd1;
      end else begin
        wr_ctr = (ctr_mem[u_idx] == 2'd0) ? 2'd0 : ctr_mem[u_idx] - 2'd1;
      end
    end
    valid_d = valid_q;
    if (wr_en) begin
      valid_d[u_idx] = 1'b1;
    end
  end

  // Lookup path with write-first forwarding when the update hits the same
  // index; outputs hold while ce is low.
  always_comb begin
    logic        byp;
    logic        e_valid;
    logic [TAG_W-1:0] e_tag;
    logic [1:0]  e_ctr;
    logic [31:0] e_target;

    byp      = wr_en && (u_idx == l_idx);
    e_valid  = byp ? 1'b1      : valid_q[l_idx];
    e_tag    = byp ? u_tag     : tag_mem[l_idx];
    e_ctr    = byp ? wr_ctr    : ctr_mem[l_idx];
    e_target = byp ? wr_target : target_mem[l_idx];

    hit_d            = hit_q;
    predict_taken_d  = predict_taken_q;
    predict_target_d = predict_target_q;
    if (bp.ce) begin
      hit_d            = e_valid && (e_tag == l_tag);
      predict_taken_d  = hit_d && e_ctr[1];
      predict_target_d = hit_d ? e_target : 32'd0;
    end
  end

  // Valid bits and prediction registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q          <= '0;
      hit_q            <= 1'b0;
      predict_taken_q  <= 1'b0;
      predict_target_q <= 32'd0;
    end else begin
      valid_q          <= valid_d;
      hit_q            <= hit_d;
      predict_taken_q  <= predict_taken_d;
      predict_target_q <= predict_target_d;
    end
  end

  // Entry payload storage; no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[u_idx]    <= u_tag;
      ctr_mem[u_idx]    <= wr_ctr;
      target_mem[u_idx] <= wr_target;
    end
  end

  assign bp.hit            = hit_q;
  assign bp.predict_taken  = predict_taken_q;
  assign bp.predict_target = predict_target_q;

`ifdef BP_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  // Count every accepted resolved branch and those flagged as mispredicted.
  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (bp.ce && bp.update_valid) begin
      stat_branches_d = stat_branches_q + 32'd1;
      if (bp.update_mispredict) begin
        stat_mispredicts_d = stat_mispredicts_q + 32'd1;
      end
    end
  end

  // Statistic registers, wrapping naturally modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches_q    <= 32'd0;
      stat_mispredicts_q <= 32'd0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign bp.stat_branches    = stat_branches_q;
  assign bp.stat_mispredicts = stat_mispredicts_q;

  logic unused_bits;
  assign unused_bits = ^{bp.lookup_pc, bp.update_pc};
`else
  assign bp.stat_branches    = 32'd0;
  assign bp.stat_mispredicts = 32'd0;

  logic unused_bits;
  assign unused_bits = ^{bp.lookup_pc, bp.update_pc, bp.update_mispredict};
`endif

endmodule

// File: tb/tb_m_branch_predictor.sv
// Directed testbench for m_branch_predictor (ENTRIES=64, TAG_W=8).
// Index is pc[7:2], tag is pc[15:8]; 0x100/0x200/0x300 share index 0.
module tb_m_branch_predictor;
  logic clk;
  logic rst;
  int   n_vectors;
  int   n_miscompares;
  int   exp_branches;
  int   exp_mispredicts;

  m_branch_predictor_if bp_if ();

  m_branch_predictor #(.ENTRIES(64), .TAG_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, advance past the edge, track expected stats.
  task automatic applyStimulus(input logic ce, input logic [31:0] lpc,
                               input logic uv, input logic [31:0] upc,
                               input logic ut, input logic [31:0] utgt,
                               input logic umis);
    bp_if.ce                = ce;
    bp_if.lookup_pc         = lpc;
    bp_if.update_valid      = uv;
    bp_if.update_pc         = upc;
    bp_if.update_taken      = ut;
    bp_if.update_target     = utgt;
    bp_if.update_mispredict = umis;
    @(posedge clk);
    #1;
    if (ce && uv) begin
      exp_branches++;
      if (umis) exp_mispredicts++;
    end
  endtask

  // Update only; the lookup goes to an index/tag that is never trained.
  task automatic train(input logic [31:0] pc, input logic taken,
                       input logic [31:0] tgt, input logic mis);
    applyStimulus(1'b1, 32'hFFC, 1'b1, pc, taken, tgt, mis);
  endtask

  task automatic checkLookup(input string tag, input logic [31:0] pc,
                             input logic e_hit, input logic e_taken,
                             input logic [31:0] e_tgt);
    applyStimulus(1'b1, pc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput({tag, ".hit"}, {31'd0, bp_if.hit}, {31'd0, e_hit});
    checkOutput({tag, ".taken"}, {31'd0, bp_if.predict_taken}, {31'd0, e_taken});
    checkOutput({tag, ".target"}, bp_if.predict_target, e_tgt);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".hit"}, {31'd0, bp_if.hit}, 32'd0);
    checkOutput({tag, ".taken"}, {31'd0, bp_if.predict_taken}, 32'd0);
    checkOutput({tag, ".target"}, bp_if.predict_target, 32'd0);
    checkOutput({tag, ".stat_br"}, bp_if.stat_branches, 32'd0);
    checkOutput({tag, ".stat_mis"}, bp_if.stat_mispredicts, 32'd0);
  endtask

  initial begin
    n_vectors       = 0;
    n_miscompares   = 0;
    exp_branches    = 0;
    exp_mispredicts = 0;
    rst                     = 1'b1;
    bp_if.ce                = 1'b0;
    bp_if.lookup_pc         = 32'd0;
    bp_if.update_valid      = 1'b0;
    bp_if.update_pc         = 32'd0;
    bp_if.update_taken      = 1'b0;
    bp_if.update_target     = 32'd0;
    bp_if.update_mispredict = 1'b0;

    #2;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;

    checkLookup("cold", 32'h100, 1'b0, 1'b0, 32'h0);

    // Allocation and counter walk: 2 -> 1 -> 0 -> 0 -> 1 -> 2 -> 3 -> 3 -> 2 -> 1
    train(32'h100, 1'b1, 32'h40, 1'b0);
    checkLookup("alloc", 32'h100, 1'b1, 1'b1, 32'h40);
    train(32'h100, 1'b0, 32'h0, 1'b1);
    checkLookup("ctr1", 32'h100, 1'b1, 1'b0, 32'h40);
    train(32'h100, 1'b0, 32'h0, 1'b0);
    checkLookup("ctr0", 32'h100, 1'b1, 1'b0, 32'h40);
    train(32'h100, 1'b0, 32'h0, 1'b0);
    checkLookup("ctr0sat", 32'h100, 1'b1, 1'b0, 32'h40);
    train(32'h100, 1'b1, 32'h48, 1'b1);
    checkLookup("ctr1up", 32'h100, 1'b1, 1'b0, 32'h48);
    train(32'h100, 1'b1, 32'h48, 1'b0);
    checkLookup("ctr2up", 32'h100, 1'b1, 1'b1, 32'h48);
    train(32'h100, 1'b1, 32'h48, 1'b0);
    checkLookup("ctr3", 32'h100, 1'b1, 1'b1, 32'h48);
    train(32'h100, 1'b1, 32'h48, 1'b0);
    checkLookup("ctr3sat", 32'h100, 1'b1, 1'b1, 32'h48);
    train(32'h100, 1'b0, 32'h0, 1'b0);
    checkLookup("ctr2dn", 32'h100, 1'b1, 1'b1, 32'h48);
    train(32'h100, 1'b0, 32'h0, 1'b0);
    checkLookup("ctr1dn", 32'h100, 1'b1, 1'b0, 32'h48);

    // Same index, different tag replaces the entry.
    train(32'h200, 1'b1, 32'h80, 1'b0);
    checkLookup("old_tag", 32'h100, 1'b0, 1'b0, 32'h0);
    checkLookup("new_tag", 32'h200, 1'b1, 1'b1, 32'h80);

    // Not-taken miss must not allocate.
    train(32'h404, 1'b0, 32'h999, 1'b0);
    checkLookup("nt_noalloc", 32'h404, 1'b0, 1'b0, 32'h0);

    // Same-cycle lookup and first update of the same PC: write-first.
    applyStimulus(1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 32'h500, 1'b0);
    checkOutput("bypass.hit", {31'd0, bp_if.hit}, 32'd1);
    checkOutput("bypass.taken", {31'd0, bp_if.predict_taken}, 32'd1);
    checkOutput("bypass.target", bp_if.predict_target, 32'h500);

    // Same-cycle lookup and update on different indices are independent.
    applyStimulus(1'b1, 32'h300, 1'b1, 32'h108, 1'b1, 32'h700, 1'b0);
    checkOutput("indep.hit", {31'd0, bp_if.hit}, 32'd1);
    checkOutput("indep.target", bp_if.predict_target, 32'h500);
    checkLookup("indep_upd", 32'h108, 1'b1, 1'b1, 32'h700);

    // ce low: outputs frozen, update dropped.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h100 + 32'(i * 4), 1'b1, 32'h504, 1'b1, 32'h900, 1'b1);
      checkOutput("ce0.hit", {31'd0, bp_if.hit}, 32'd1);
      checkOutput("ce0.taken", {31'd0, bp_if.predict_taken}, 32'd1);
      checkOutput("ce0.target", bp_if.predict_target, 32'h700);
    end
    checkLookup("ce0_untrained", 32'h504, 1'b0, 1'b0, 32'h0);

`ifdef BP_STATS_EN
    checkOutput("stat_br", bp_if.stat_branches, 32'(exp_branches));
    checkOutput("stat_mis", bp_if.stat_mispredicts, 32'(exp_mispredicts));
`else
    checkOutput("stat_br", bp_if.stat_branches, 32'd0);
    checkOutput("stat_mis", bp_if.stat_mispredicts, 32'd0);
`endif

    // Mid-stream asynchronous reset clears outputs and forgets entries.
    checkLookup("pre_rst", 32'h300, 1'b1, 1'b1, 32'h500);
    #2;
    rst = 1'b1;
    #1;
    checkAllZero("mid_rst");
    #1;
    rst = 1'b0;
    checkLookup("post_rst", 32'h300, 1'b0, 1'b0, 32'h0);
    checkLookup("post_rst2", 32'h108, 1'b0, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end
endmodule
